countdown_timer: RTL

Loadable down-counter with terminal-count detection and optional auto-reload. It is the complement of the team's free-running 4-bit up-counter: software or a controlling FSM loads a start value, and the block counts down to zero under `enable`. When it reaches zero it flags terminal count and, if configured, reloads itself. Typical uses are timeouts, inter-packet gaps and rate dividers in the same testbench/RTL tree.

---
 rtl/countdown_pkg.sv | 8 +
 rtl/countdown_timer.sv | 80 ++++++++
 2 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cd_state_t;

  localparam int unsigned CD_WIDTH_DEFAULT = 4;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse and no wrap at zero.
// Optional auto-reload at terminal count is enabled by defining COUNTDOWN_RELOAD_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
`ifdef COUNTDOWN_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             reload_sel_c;

  // Without the reload feature the terminal step always lands in DONE.
`ifdef COUNTDOWN_RELOAD_EN
  assign reload_sel_c = auto_reload;
`else
  assign reload_sel_c = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && enable) begin
      if (cnt_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (reload_sel_c) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule : countdown_timer
